membus_initiator: RTL and testbench

//  Processor-side initiator for the 36-bit memory bus. It issues one cycle at a time:

---
 rtl/membus_initiator_if.sv | 50 +++++
 rtl/membus_initiator.sv | 218 +++++++++++++++++++++
 tb/tb_membus_initiator.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/membus_initiator_if.sv
// membus_initiator_if
//   Groups the local request/response port and the 36-bit memory bus
//   signals of one processor-side initiator.
//   master : used by membus_initiator (drives bus requests, returns responses)
//   slave  : used by the environment (requester + memory controller side)
//   Bit numbering: 18-bit addresses use [17:0] with bit 17 = bus bit 18,
//   36-bit words use [35:0] with bit 35 = bus bit 0.
interface membus_initiator_if;
    // local request / response port
    logic        req_valid;
    logic        req_ready;
    logic        req_rd;
    logic        req_wr;
    logic [17:0] req_addr;
    logic [35:0] req_wdata;
    logic        wdata_valid;
    logic [35:0] wdata;
    logic        rsp_valid;
    logic [35:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    // memory bus
    logic        membus_rq_cyc;
    logic        membus_rd_rq;
    logic        membus_wr_rq;
    logic [3:0]  membus_sel;
    logic [14:0] membus_ma;
    logic        membus_fmc_select;
    logic [35:0] membus_mb_out;
    logic        membus_wr_rs;
    logic        membus_addr_ack;
    logic        membus_rd_rs;
    logic [35:0] membus_mb_in;

    modport master (
        input  req_valid, req_rd, req_wr, req_addr, req_wdata, wdata_valid, wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        output membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_sel, membus_ma,
        output membus_fmc_select, membus_mb_out, membus_wr_rs,
        input  membus_addr_ack, membus_rd_rs, membus_mb_in
    );

    modport slave (
        output req_valid, req_rd, req_wr, req_addr, req_wdata, wdata_valid, wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        input  membus_rq_cyc, membus_rd_rq, membus_wr_rq, membus_sel, membus_ma,
        input  membus_fmc_select, membus_mb_out, membus_wr_rs,
        output membus_addr_ack, membus_rd_rs, membus_mb_in
    );
endinterface

// File: rtl/membus_initiator.sv
// membus_initiator
//   Processor-side initiator for the 36-bit memory bus. Runs one read, write
//   or read-modify-write cycle at a time and reports read data or a timeout
//   error on a one-cycle response pulse.
// Ports
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : membus_initiator_if.master (local req/rsp + memory bus)
// Parameters
//   TIMEOUT     : cycles without addr_ack (REQ) or rd_rs (RDWAIT) before abort
//   MB_SETTLE   : cycles mb_out is driven before the wr_rs pulse (>= 1)
//   FMC_PRESENT : nonzero -> addresses 0..15 assert membus_fmc_select
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | ready for a local request
// S_REQ     | rq_cyc asserted, waiting for addr_ack
// S_RDWAIT  | accumulating mb_in, waiting for rd_rs
// S_WRDATA  | RMW: waiting for write data from the requester
// S_WRDRIVE | driving mb_out for MB_SETTLE cycles
// S_WRRS    | one-cycle wr_rs pulse with mb_out still driven
module membus_initiator #(
    parameter int TIMEOUT     = 1000,
    parameter int MB_SETTLE   = 4,
    parameter int FMC_PRESENT = 1
) (
    input logic                 clk,
    input logic                 reset_n,
    membus_initiator_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_RDWAIT, S_WRDATA, S_WRDRIVE, S_WRRS
    } state_t;

    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT - 1);
    localparam logic [7:0]  SETTLE_LOAD = 8'(MB_SETTLE - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [17:0] r_addr;
    logic        r_rd;
    logic        r_wr;
    logic [35:0] r_wdata;
    logic [35:0] r_rdbuf;
    logic [15:0] r_tmo_cnt;
    logic [7:0]  r_settle;
    logic        r_rsp_valid;
    logic [35:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic        w_tmo_hit;
    logic        w_fmc;
    logic [35:0] w_rd_word;

    // The expiry cycle is the TIMEOUT-th cycle in REQ/RDWAIT; a handshake
    // arriving in that same cycle takes priority over the abort.
    assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
    assign w_fmc     = (FMC_PRESENT != 0) && (r_addr[17:4] == 14'd0);
    assign w_rd_word = r_rdbuf | bus.membus_mb_in;

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                // rd=wr=0 is answered directly from IDLE without a bus cycle
                if (bus.req_valid && (bus.req_rd || bus.req_wr)) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.membus_addr_ack) begin
                    w_state_nxt = r_rd ? S_RDWAIT : S_WRDRIVE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RDWAIT: begin
                if (bus.membus_rd_rs) begin
                    w_state_nxt = r_wr ? S_WRDATA : S_IDLE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WRDATA: begin
                if (bus.wdata_valid) begin
                    w_state_nxt = S_WRDRIVE;
                end
            end
            S_WRDRIVE: begin
                if (r_settle == 8'd0) begin
                    w_state_nxt = S_WRRS;
                end
            end
            S_WRRS:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // datapath: request latch, read buffer, timers, response register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_wdata     <= '0;
            r_rdbuf     <= '0;
            r_tmo_cnt   <= '0;
            r_settle    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_addr    <= bus.req_addr;
                        r_rd      <= bus.req_rd;
                        r_wr      <= bus.req_wr;
                        r_wdata   <= bus.req_wdata;
                        r_rdbuf   <= '0;
                        r_tmo_cnt <= '0;
                        if (!bus.req_rd && !bus.req_wr) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.membus_addr_ack) begin
                        r_tmo_cnt <= '0;
                        r_settle  <= SETTLE_LOAD;
                    end else if (w_tmo_hit) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
                end
                S_RDWAIT: begin
                    r_rdbuf <= w_rd_word;
                    if (bus.membus_rd_rs) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_rd_word;
                    end else if (w_tmo_hit) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
                end
                S_WRDATA: begin
                    if (bus.wdata_valid) begin
                        r_wdata  <= bus.wdata;
                        r_settle <= SETTLE_LOAD;
                    end
                end
                S_WRDRIVE: begin
                    if (r_settle != 8'd0) begin
                        r_settle <= r_settle - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // outputs decoded from state so an async reset drops the bus at once
    always_comb begin
        bus.req_ready         = (r_state == S_IDLE);
        bus.busy              = (r_state != S_IDLE);
        bus.membus_rq_cyc     = 1'b0;
        bus.membus_rd_rq      = 1'b0;
        bus.membus_wr_rq      = 1'b0;
        bus.membus_sel        = '0;
        bus.membus_ma         = '0;
        bus.membus_fmc_select = 1'b0;
        bus.membus_mb_out     = '0;
        bus.membus_wr_rs      = 1'b0;
        if (r_state != S_IDLE) begin
            bus.membus_sel        = r_addr[17:14];
            bus.membus_ma         = r_addr[14:0];
            bus.membus_fmc_select = w_fmc;
        end
        case (r_state)
            S_REQ: begin
                bus.membus_rq_cyc = 1'b1;
                bus.membus_rd_rq  = r_rd;
                bus.membus_wr_rq  = r_wr;
            end
            S_WRDRIVE: bus.membus_mb_out = r_wdata;
            S_WRRS: begin
                bus.membus_mb_out = r_wdata;
                bus.membus_wr_rs  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_membus_initiator.sv
module tb_membus_initiator;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_rsp = 0;

    typedef struct packed {
        logic [35:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;

    membus_initiator_if bus ();

    membus_initiator #(
        .TIMEOUT     (20),
        .MB_SETTLE   (4),
        .FMC_PRESENT (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0o expected %0o", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // response scoreboard: every rsp_valid cycle must match the next expected entry
    always @(negedge clk) begin
        if (reset_n && bus.rsp_valid) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(mon_e.rdata));
                chk("rsp_err", 64'(bus.rsp_err), 64'(mon_e.err));
            end
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [17:0] a, input logic [35:0] d);
        int n;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            tick();
            n++;
        end
        chk("req_ready", 64'(bus.req_ready), 64'd1);
        bus.req_rd    = rd;
        bus.req_wr    = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int exp_rsp, input int rsp_before);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_rsp_count"}, 64'(n_rsp - rsp_before), 64'(exp_rsp));
    endtask

    task automatic write_phase(input string tag, input logic [35:0] d);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk({tag, "_mb_settle"}, 64'(bus.membus_mb_out), 64'(d));
            chk({tag, "_wr_rs_early"}, 64'(bus.membus_wr_rs), 64'd0);
            tick();
        end
        @(negedge clk);
        chk({tag, "_wr_rs"}, 64'(bus.membus_wr_rs), 64'd1);
        chk({tag, "_mb_at_wr_rs"}, 64'(bus.membus_mb_out), 64'(d));
        tick();
        @(negedge clk);
        chk({tag, "_wr_rs_done"}, 64'(bus.membus_wr_rs), 64'd0);
        chk({tag, "_mb_released"}, 64'(bus.membus_mb_out), 64'd0);
        chk({tag, "_ready_after"}, 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        int base;
        int hi;
        logic bad;
        bus.req_valid = 0; bus.req_rd = 0; bus.req_wr = 0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.wdata_valid = 0; bus.wdata = '0;
        bus.membus_addr_ack = 0; bus.membus_rd_rs = 0; bus.membus_mb_in = '0;

        repeat (3) tick();
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_rq_cyc", 64'(bus.membus_rq_cyc), 64'd0);
        chk("rst_sel", 64'(bus.membus_sel), 64'd0);
        chk("rst_mb_out", 64'(bus.membus_mb_out), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // 1: plain read, ack after 5 cycles, data one cycle before rd_rs
        base = n_rsp;
        exp_q.push_back('{rdata: 36'o123456701234, err: 1'b0});
        issue(1'b1, 1'b0, 18'o001234, 36'd0);
        @(negedge clk);
        chk("t1_rq_cyc", 64'(bus.membus_rq_cyc), 64'd1);
        chk("t1_rd_rq", 64'(bus.membus_rd_rq), 64'd1);
        chk("t1_wr_rq", 64'(bus.membus_wr_rq), 64'd0);
        chk("t1_sel", 64'(bus.membus_sel), 64'd0);
        chk("t1_ma", 64'(bus.membus_ma), 64'(15'o01234));
        chk("t1_fmc", 64'(bus.membus_fmc_select), 64'd0);
        repeat (4) tick();
        bus.membus_addr_ack = 1'b1;
        tick();
        bus.membus_addr_ack = 1'b0;
        @(negedge clk);
        chk("t1_rq_drop", 64'(bus.membus_rq_cyc), 64'd0);
        chk("t1_ma_held", 64'(bus.membus_ma), 64'(15'o01234));
        bus.membus_mb_in = 36'o123456701234;
        tick();
        bus.membus_mb_in = '0;
        bus.membus_rd_rs = 1'b1;
        tick();
        bus.membus_rd_rs = 1'b0;
        drain("t1", 1, base);

        // 2: plain write, immediate ack
        base = n_rsp;
        issue(1'b0, 1'b1, 18'o400017, 36'o777000777000);
        @(negedge clk);
        chk("t2_sel", 64'(bus.membus_sel), 64'o10);
        chk("t2_wr_rq", 64'(bus.membus_wr_rq), 64'd1);
        chk("t2_rd_rq", 64'(bus.membus_rd_rq), 64'd0);
        chk("t2_mb_in_req", 64'(bus.membus_mb_out), 64'd0);
        bus.membus_addr_ack = 1'b1;
        tick();
        bus.membus_addr_ack = 1'b0;
        write_phase("t2", 36'o777000777000);
        drain("t2", 0, base);

        // 3: RMW at fast-memory address, write data 10 cycles after response
        base = n_rsp;
        exp_q.push_back('{rdata: 36'o5, err: 1'b0});
        issue(1'b1, 1'b1, 18'o000005, 36'o777);
        @(negedge clk);
        chk("t3_fmc", 64'(bus.membus_fmc_select), 64'd1);
        chk("t3_rd_rq", 64'(bus.membus_rd_rq), 64'd1);
        chk("t3_wr_rq", 64'(bus.membus_wr_rq), 64'd1);
        bus.membus_addr_ack = 1'b1;
        tick();
        bus.membus_addr_ack = 1'b0;
        bus.membus_mb_in = 36'o5;
        bus.membus_rd_rs = 1'b1;
        tick();
        bus.membus_mb_in = '0;
        bus.membus_rd_rs = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.membus_mb_out != 36'd0 || bus.membus_wr_rs || !bus.busy) bad = 1'b1;
            tick();
        end
        chk("t3_wrdata_wait", 64'(bad), 64'd0);
        bus.wdata = 36'o6;
        bus.wdata_valid = 1'b1;
        tick();
        bus.wdata_valid = 1'b0;
        bus.wdata = '0;
        write_phase("t3", 36'o6);
        drain("t3", 1, base);

        // 4: no addr_ack -> timeout after exactly 20 rq_cyc cycles
        base = n_rsp;
        exp_q.push_back('{rdata: 36'd0, err: 1'b1});
        issue(1'b1, 1'b0, 18'o000100, 36'd0);
        hi = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.membus_rq_cyc) hi++;
            tick();
        end
        chk("t4_rq_cyc_cycles", 64'(hi), 64'd20);
        chk("t4_rq_cyc_off", 64'(bus.membus_rq_cyc), 64'd0);
        chk("t4_rd_rq_off", 64'(bus.membus_rd_rq), 64'd0);
        chk("t4_sel_ma_off", 64'({bus.membus_sel, bus.membus_ma, bus.membus_fmc_select}), 64'd0);
        chk("t4_mb_off", 64'(bus.membus_mb_out), 64'd0);
        drain("t4", 1, base);

        // 5: handshakes in the expiry cycle of REQ and of RDWAIT win
        base = n_rsp;
        exp_q.push_back('{rdata: 36'o42, err: 1'b0});
        issue(1'b1, 1'b0, 18'o000200, 36'd0);
        repeat (19) tick();
        bus.membus_addr_ack = 1'b1;
        tick();
        bus.membus_addr_ack = 1'b0;
        @(negedge clk);
        chk("t5_req_expiry_busy", 64'(bus.busy), 64'd1);
        repeat (19) tick();
        bus.membus_mb_in = 36'o42;
        bus.membus_rd_rs = 1'b1;
        tick();
        bus.membus_mb_in = '0;
        bus.membus_rd_rs = 1'b0;
        drain("t5", 1, base);

        // 6: async reset while driving write data, then a normal read
        base = n_rsp;
        issue(1'b0, 1'b1, 18'o000777, 36'o555);
        bus.membus_addr_ack = 1'b1;
        tick();
        bus.membus_addr_ack = 1'b0;
        tick();
        #2;
        chk("t6_mb_before_rst", 64'(bus.membus_mb_out), 64'o555);
        reset_n = 1'b0;
        #1;
        chk("t6_mb_rst", 64'(bus.membus_mb_out), 64'd0);
        chk("t6_rq_rst", 64'(bus.membus_rq_cyc), 64'd0);
        chk("t6_wr_rs_rst", 64'(bus.membus_wr_rs), 64'd0);
        chk("t6_ready_rst", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        exp_q.push_back('{rdata: 36'o17, err: 1'b0});
        issue(1'b1, 1'b0, 18'o000003, 36'd0);
        bus.membus_addr_ack = 1'b1;
        tick();
        bus.membus_addr_ack = 1'b0;
        bus.membus_mb_in = 36'o17;
        bus.membus_rd_rs = 1'b1;
        tick();
        bus.membus_mb_in = '0;
        bus.membus_rd_rs = 1'b0;
        drain("t6", 1, base);

        // 7: rd=wr=0 request answered without a bus cycle
        base = n_rsp;
        exp_q.push_back('{rdata: 36'd0, err: 1'b0});
        issue(1'b0, 1'b0, 18'o000010, 36'd0);
        @(negedge clk);
        chk("t7_no_rq_cyc", 64'(bus.membus_rq_cyc), 64'd0);
        chk("t7_not_busy", 64'(bus.busy), 64'd0);
        drain("t7", 1, base);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
